// File: rtl/pipeline_combine_masked_fifo.sv
// Masked valid/ready join with one FIFO per input channel.
// A transaction pops the head of every channel whose mask bit is set.
module pipeline_combine_masked_fifo #(
  parameter  int N     = 2,
  parameter  int W     = 32,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           i_valid,
  output logic [N-1:0]           i_ready,
  input  logic [N-1:0][W-1:0]    i_data,
  input  logic [N-1:0]           i_mask,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic [N-1:0][W-1:0]    o_data,
  output logic [N-1:0][CW-1:0]   o_count
);

  logic [W-1:0]          r_mem [N][DEPTH];
  logic [N-1:0][CW-1:0]  r_count;
  logic [N-1:0][PW-1:0]  r_wptr;
  logic [N-1:0][PW-1:0]  r_rptr;

  logic [N-1:0]          w_full;
  logic [N-1:0]          w_nonempty;
  logic [N-1:0]          w_push;
  logic [N-1:0]          w_pop;
  logic                  w_valid;
  logic                  w_fire;

  function automatic logic [PW-1:0] f_next_ptr(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Per-channel status decode from registered occupancy
  always_comb begin
    w_full     = '0;
    w_nonempty = '0;
    for (int i = 0; i < N; i++) begin
      w_full[i]     = (r_count[i] == CW'(DEPTH));
      w_nonempty[i] = (r_count[i] != CW'(0));
    end
  end

  assign i_ready = ~w_full;
  assign w_push  = i_valid & ~w_full;

  // Join: every masked channel must have a head entry
  always_comb begin
    w_valid = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (i_mask[i] && !w_nonempty[i]) begin
        w_valid = 1'b0;
      end else begin
        w_valid = w_valid;
      end
    end
  end

  assign o_valid = w_valid;
  assign w_fire  = w_valid & o_ready;
  assign w_pop   = {N{w_fire}} & i_mask;

  // Head data of masked, non-empty channels; zero elsewhere
  always_comb begin
    o_data = '0;
    for (int i = 0; i < N; i++) begin
      if (i_mask[i] && w_nonempty[i]) begin
        o_data[i] = r_mem[i][r_rptr[i]];
      end else begin
        o_data[i] = '0;
      end
    end
  end

  // Storage writes; contents need no reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!rst && w_push[i]) begin
        r_mem[i][r_wptr[i]] <= i_data[i];
      end
    end
  end

  // Pointer and occupancy update; push and pop together leave count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (w_push[i]) begin
          r_wptr[i] <= f_next_ptr(r_wptr[i]);
        end
        if (w_pop[i]) begin
          r_rptr[i] <= f_next_ptr(r_rptr[i]);
        end
        case ({w_push[i], w_pop[i]})
          2'b10:   r_count[i] <= r_count[i] + CW'(1);
          2'b01:   r_count[i] <= r_count[i] - CW'(1);
          default: r_count[i] <= r_count[i];
        endcase
      end
    end
  end

  assign o_count = r_count;

  pipeline_combine_masked_fifo_chk #(
    .N     (N),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_chk (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_nonempty (w_nonempty),
    .i_count    (r_count)
  );

endmodule

// Simulation-only invariants on the per-channel FIFOs.
module pipeline_combine_masked_fifo_chk #(
  parameter int N     = 2,
  parameter int DEPTH = 2,
  parameter int CW    = 2
) (
  input logic                  clk,
  input logic                  rst,
  input logic [N-1:0]          i_push,
  input logic [N-1:0]          i_pop,
  input logic [N-1:0]          i_nonempty,
  input logic [N-1:0][CW-1:0]  i_count
);

  for (genvar g = 0; g < N; g++) begin : g_chk
    a_no_pop_empty : assert property (@(posedge clk) disable iff (rst)
      i_pop[g] |-> i_nonempty[g]);
    a_count_bound  : assert property (@(posedge clk) disable iff (rst)
      i_count[g] <= CW'(DEPTH));
    a_no_push_full : assert property (@(posedge clk) disable iff (rst)
      (i_count[g] == CW'(DEPTH)) |-> !i_push[g]);
  end

endmodule

// File: tb/tb_pipeline_combine_masked_fifo.sv
// Directed self-checking bench for pipeline_combine_masked_fifo (N=2, DEPTH=2).
module tb_pipeline_combine_masked_fifo;

  localparam int N     = 2;
  localparam int W     = 32;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic                  clk;
  logic                  rst;
  logic [N-1:0]          i_valid;
  logic [N-1:0]          i_ready;
  logic [N-1:0][W-1:0]   i_data;
  logic [N-1:0]          i_mask;
  logic                  o_valid;
  logic                  o_ready;
  logic [N-1:0][W-1:0]   o_data;
  logic [N-1:0][CW-1:0]  o_count;

  int n_assert = 0;
  int n_fail   = 0;

  pipeline_combine_masked_fifo #(
    .N     (N),
    .W     (W),
    .DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_data  (i_data),
    .i_mask  (i_mask),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_count (o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    i_valid = 2'b00;
    i_data  = '0;
    i_mask  = 2'b11;
    o_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset / idle
    chk("rst_i_ready", 32'(i_ready), 32'h3);
    chk("rst_o_valid", 32'(o_valid), 32'h0);
    chk("rst_count0",  32'(o_count[0]), 32'h0);
    chk("rst_count1",  32'(o_count[1]), 32'h0);
    chk("rst_data0",   o_data[0], 32'h0);
    i_mask = 2'b00;
    #1;
    chk("empty_mask_valid", 32'(o_valid), 32'h1);

    // Aligned join
    i_mask    = 2'b11;
    o_ready   = 1'b1;
    i_valid   = 2'b11;
    i_data[0] = 32'hA;
    i_data[1] = 32'hB;
    tick();
    i_valid = 2'b00;
    #1;
    chk("align_valid", 32'(o_valid), 32'h1);
    chk("align_data0", o_data[0], 32'hA);
    chk("align_data1", o_data[1], 32'hB);
    chk("align_count0_pre", 32'(o_count[0]), 32'h1);
    tick();
    chk("align_count0", 32'(o_count[0]), 32'h0);
    chk("align_count1", 32'(o_count[1]), 32'h0);
    chk("align_valid_after", 32'(o_valid), 32'h0);

    // Skewed arrival: ch0 at cycle 0, ch1 at cycle 3
    i_valid   = 2'b01;
    i_data[0] = 32'h1;
    tick();
    i_valid = 2'b00;
    #1;
    chk("skew_valid_c1", 32'(o_valid), 32'h0);
    tick();
    chk("skew_valid_c2", 32'(o_valid), 32'h0);
    tick();
    i_valid   = 2'b10;
    i_data[1] = 32'h2;
    #1;
    chk("skew_valid_c3", 32'(o_valid), 32'h0);
    chk("skew_count0_hold", 32'(o_count[0]), 32'h1);
    tick();
    i_valid = 2'b00;
    #1;
    chk("skew_valid_c4", 32'(o_valid), 32'h1);
    chk("skew_data0", o_data[0], 32'h1);
    chk("skew_data1", o_data[1], 32'h2);
    tick();
    chk("skew_count0_end", 32'(o_count[0]), 32'h0);
    chk("skew_count1_end", 32'(o_count[1]), 32'h0);

    // Masked-out channel
    o_ready   = 1'b0;
    i_valid   = 2'b11;
    i_data[0] = 32'h5;
    i_data[1] = 32'h7;
    tick();
    i_valid = 2'b00;
    i_mask  = 2'b01;
    #1;
    chk("mask10_valid", 32'(o_valid), 32'h1);
    chk("mask10_data0", o_data[0], 32'h5);
    chk("mask10_data1", o_data[1], 32'h0);
    o_ready = 1'b1;
    tick();
    o_ready = 1'b0;
    #1;
    chk("mask10_count0", 32'(o_count[0]), 32'h0);
    chk("mask10_count1", 32'(o_count[1]), 32'h1);
    i_mask = 2'b10;
    #1;
    chk("mask01_valid", 32'(o_valid), 32'h1);
    chk("mask01_data0", o_data[0], 32'h0);
    chk("mask01_data1", o_data[1], 32'h7);
    o_ready = 1'b1;
    tick();
    o_ready = 1'b0;
    #1;
    chk("mask01_count1", 32'(o_count[1]), 32'h0);

    // Backpressure / full on ch0, producer keeps valid high while full
    i_mask    = 2'b01;
    i_valid   = 2'b01;
    i_data[0] = 32'h10;
    tick();
    i_data[0] = 32'h11;
    tick();
    chk("full_ready0", 32'(i_ready[0]), 32'h0);
    chk("full_count0", 32'(o_count[0]), 32'h2);
    i_data[0] = 32'h12;
    tick();
    i_valid = 2'b00;
    #1;
    chk("full_hold_count0", 32'(o_count[0]), 32'h2);
    chk("full_head0", o_data[0], 32'h10);
    o_ready = 1'b1;
    tick();
    chk("bp_ready0_after_pop", 32'(i_ready[0]), 32'h1);
    chk("bp_count0_mid", 32'(o_count[0]), 32'h1);
    chk("bp_data0_second", o_data[0], 32'h11);
    tick();
    chk("bp_count0_end", 32'(o_count[0]), 32'h0);
    chk("bp_valid_empty", 32'(o_valid), 32'h0);
    o_ready = 1'b0;

    // Reset mid-stream
    i_valid   = 2'b11;
    i_data[0] = 32'h20;
    i_data[1] = 32'h30;
    tick();
    i_valid   = 2'b01;
    i_data[0] = 32'h21;
    tick();
    i_valid = 2'b00;
    i_mask  = 2'b11;
    #1;
    chk("pre_rst_count0", 32'(o_count[0]), 32'h2);
    chk("pre_rst_count1", 32'(o_count[1]), 32'h1);
    chk("pre_rst_valid",  32'(o_valid), 32'h1);
    rst     = 1'b1;
    o_ready = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_count0", 32'(o_count[0]), 32'h0);
    chk("mid_rst_count1", 32'(o_count[1]), 32'h0);
    chk("mid_rst_valid",  32'(o_valid), 32'h0);
    chk("mid_rst_ready",  32'(i_ready), 32'h3);
    chk("mid_rst_data1",  o_data[1], 32'h0);

    // Simultaneous push and pop on ch0
    o_ready   = 1'b0;
    i_mask    = 2'b01;
    i_valid   = 2'b01;
    i_data[0] = 32'h40;
    tick();
    i_data[0] = 32'h41;
    o_ready   = 1'b1;
    #1;
    chk("pp_head0", o_data[0], 32'h40);
    tick();
    i_valid = 2'b00;
    #1;
    chk("pp_count0", 32'(o_count[0]), 32'h1);
    chk("pp_data0_next", o_data[0], 32'h41);
    tick();
    chk("pp_count0_end", 32'(o_count[0]), 32'h0);
    o_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
